exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
- Execute stage sitting directly downstream of the register file read ports and upstream of its write port.
- Consumes rs/rt operand values, performs one 3-bit-encoded ALU op, and returns a registered write-back pulse.
- The pulse carries a result for rs and a companion value for the COUT register.
- Single-cycle ops complete in 1 cycle; MUL is an iterative multi-cycle op with a busy/done handshake.

Parameters:
- DW, 8, datapath width (operands, result, COUT).
- MUL_STEPS, DW, multiplier iterations; equals DW, not independently tunable.

Ports:
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  3  operation code, sampled with start
- a_i  input  DW  rs operand value
- b_i  input  DW  rt operand value
- busy  output  1  high while MUL is iterating
- done  output  1  one-cycle completion pulse
- write_enable  output  1  rs write strobe; equals done
- cout_write_enable  output  1  COUT write strobe; equals done
- write_data  output  DW  result to rs
- cout_data  output  DW  value to COUT

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high. Reset drives busy, done, write_enable and cout_write_enable to 0, and write_data and cout_data to 0. FSM goes to IDLE; MUL counter goes to 0.
- Op encodings: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- Operand capture: a_i, b_i and op are captured at the accepting edge. Later changes on the inputs do not affect an op in flight.
- FSM states: IDLE, MUL.
  - IDLE + start + op!=MUL: compute combinationally and register at the same edge. done, write_enable and cout_write_enable are high for exactly the next cycle. Latency 1.
  - IDLE + start + op==MUL: go to MUL, busy=1, counter=0.
  - MUL: one shift-add step per edge. After step MUL_STEPS (edge E+8 for DW=8), return to IDLE. busy=0 and done=1 in the same cycle. Latency 8.
  - start while busy=1 is ignored, with no queueing.
  - start in the same cycle that done is high is accepted (back-to-back issue).
- Arithmetic, all unsigned:
  - ADD: {c,r}=a+b, write_data=r, cout_data={0..,c}.
  - SUB: r=a-b mod 2^DW, cout_data=1 if a<b else 0.
  - AND/OR/XOR: bitwise, cout_data=0.
  - SHL: {cout_data,write_data}=({DW'0,a}<<b[2:0]).
  - SHR: {write_data,cout_data}=({a,DW'0}>>b[2:0]).
  - MUL: 2*DW-bit product, low half to write_data, high half to cout_data.
- Every completed op pulses both write strobes; COUT is always rewritten.
- write_data and cout_data hold their last values when done=0.
- Reset mid-MUL: abort and return to IDLE. No done or write pulse is produced for the aborted op.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined: op 111 is the iterative MUL as above.
- Undefined: no multiplier logic is built and busy is tied to 0. Op 111 becomes MOV: write_data=b, cout_data=0, latency 1.

Decomposition:
- Package exec_pkg holds: op_t enum (the eight codes above), DW_DEFAULT=8, and the state_t enum {IDLE, MUL}.
- One sub-module, mul_iter: shift-add unsigned multiplier with load/step/done. Instantiated only under EXEC_MUL_EN.

Test Plan:
- ADD a=F0 b=20, start 1 cycle: next cycle done=1, write_data=10, cout_data=01. Following cycle done=0.
- SUB a=05 b=07: write_data=FE, cout_data=01. SHL a=81 b=01: write_data=02, cout_data=01. SHR a=03 b=01: write_data=01, cout_data=80.
- MUL a=FF b=FF: busy=1 for cycles 1-7, done with busy=0 at cycle 8, write_data=01, cout_data=FE. A start/op=ADD at cycle 3 is ignored (exactly one done pulse).
- Back-to-back: ADD accepted during the MUL done cycle produces its done exactly one cycle later with the correct ADD result.
- Reset asserted at MUL cycle 4: next cycle busy=0, done=0. No write pulse within the following 10 cycles; outputs are 0.
- EXEC_MUL_EN undefined, op=111 a=12 b=34: next cycle write_data=34, cout_data=00, busy never 1.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU op encodings, FSM states, default width.
package exec_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/exec_unit_mul_iter.sv
// Iterative shift-add unsigned multiplier: one multiplier bit consumed per step.
module mul_iter
  import exec_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  output logic            o_done,
  output logic [2*DW-1:0] o_prod
);

  localparam int CW = $clog2(DW + 1);

  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_mcand;
  logic [2*DW-1:0] r_p;
  logic [DW:0]     w_sum;
  logic [2*DW-1:0] w_next;

  // Upper half accumulates; lower half holds the not-yet-consumed multiplier bits.
  assign w_sum  = {1'b0, r_p[2*DW-1:DW]} + (r_p[0] ? {1'b0, r_mcand} : {(DW+1){1'b0}});
  assign w_next = {w_sum, r_p[DW-1:1]};
  assign o_prod = w_next;
  assign o_done = i_step && (r_cnt == CW'(DW - 1));

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_mcand <= i_a;
      r_p     <= {{DW{1'b0}}, i_b};
    end else if (i_step) begin
      r_p <= w_next;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus an optional iterative MUL (enabled by EXEC_MUL_EN;
// without it op 111 is MOV and busy is tied low). Results leave as a registered write-back pulse.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          busy,
  output logic          done,
  output logic          write_enable,
  output logic          cout_write_enable,
  output logic [DW-1:0] write_data,
  output logic [DW-1:0] cout_data
);

  state_t          r_state;
  logic            r_done;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_cdata;
  logic [DW-1:0]   w_res;
  logic [DW-1:0]   w_cout;
  logic [2*DW-1:0] w_wide;
  logic            w_accept;
  logic            w_is_mul;
  logic            w_issue_single;

  assign w_accept       = (r_state == IDLE) && start;
  assign w_issue_single = w_accept && !w_is_mul;

  always_comb begin
    w_res  = '0;
    w_cout = '0;
    w_wide = '0;
    case (op_t'(op))
      OP_ADD: {w_cout[0], w_res} = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB: begin
        w_res     = a_i - b_i;
        w_cout[0] = (a_i < b_i);
      end
      OP_AND: w_res = a_i & b_i;
      OP_OR:  w_res = a_i | b_i;
      OP_XOR: w_res = a_i ^ b_i;
      OP_SHL: begin
        w_wide          = {{DW{1'b0}}, a_i} << b_i[2:0];
        {w_cout, w_res} = w_wide;
      end
      OP_SHR: begin
        w_wide          = {a_i, {DW{1'b0}}} >> b_i[2:0];
        {w_res, w_cout} = w_wide;
      end
`ifndef EXEC_MUL_EN
      OP_MUL: w_res = b_i;
`endif
      default: ;
    endcase
  end

`ifdef EXEC_MUL_EN
  logic            w_mul_load;
  logic            w_mul_step;
  logic            w_mul_done;
  logic [2*DW-1:0] w_prod;

  assign w_is_mul   = (op == OP_MUL);
  assign w_mul_load = w_accept && w_is_mul;
  assign w_mul_step = (r_state == MUL);
  assign busy       = (r_state == MUL);

  mul_iter #(.DW(DW)) u_mul (
    .clk    (clk),
    .i_rst  (reset),
    .i_load (w_mul_load),
    .i_step (w_mul_step),
    .i_a    (a_i),
    .i_b    (b_i),
    .o_done (w_mul_done),
    .o_prod (w_prod)
  );
`else
  assign w_is_mul = 1'b0;
  assign busy     = 1'b0;
`endif

  // Write-back register: done and both strobes pulse for exactly one cycle per completed op.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_wdata <= '0;
      r_cdata <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_issue_single) begin
        r_done  <= 1'b1;
        r_wdata <= w_res;
        r_cdata <= w_cout;
      end
`ifdef EXEC_MUL_EN
      else if (w_mul_load) begin
        r_state <= MUL;
      end else if (w_mul_done) begin
        r_state <= IDLE;
        r_done  <= 1'b1;
        r_wdata <= w_prod[DW-1:0];
        r_cdata <= w_prod[2*DW-1:DW];
      end
`endif
    end
  end

  assign done              = r_done;
  assign write_enable      = r_done;
  assign cout_write_enable = r_done;
  assign write_data        = r_wdata;
  assign cout_data         = r_cdata;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed plan vectors plus randomized ops vs. an arithmetic model.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] a_i = 8'd0;
  logic [7:0] b_i = 8'd0;
  logic       busy, done, write_enable, cout_write_enable;
  logic [7:0] write_data, cout_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit busy_seen = 1'b0;

  exec_unit #(.DW(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .op                (op),
    .a_i               (a_i),
    .b_i               (b_i),
    .busy              (busy),
    .done              (done),
    .write_enable      (write_enable),
    .cout_write_enable (cout_write_enable),
    .write_data        (write_data),
    .cout_data         (cout_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (busy === 1'b1) busy_seen <= 1'b1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // Returns {cout, result} computed with plain integer arithmetic.
  function automatic logic [15:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int unsigned ua, ub, r;
    ua = a; ub = b;
    case (o)
      3'd0: begin r = ua + ub; return {8'(r >> 8), 8'(r)}; end
      3'd1: begin r = ua - ub; return {8'(ua < ub), 8'(r)}; end
      3'd2: return {8'h00, a & b};
      3'd3: return {8'h00, a | b};
      3'd4: return {8'h00, a ^ b};
      3'd5: begin r = ua << (ub % 8); return {8'(r >> 8), 8'(r)}; end
      3'd6: begin r = (ua * 256) >> (ub % 8); return {8'(r), 8'(r >> 8)}; end
      default: begin
`ifdef EXEC_MUL_EN
        r = ua * ub; return {8'(r >> 8), 8'(r)};
`else
        return {8'h00, b};
`endif
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; op = o; a_i = a; b_i = b;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    issue(3'd0, 8'h55, 8'h66);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_tests++;
    if ({busy, done, write_enable, cout_write_enable} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy/done/we/cwe=%b expected 0000",
               {busy, done, write_enable, cout_write_enable});
    end
    n_tests++;
    if ({cout_data, write_data} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: got cout=%h wd=%h expected 00 00", cout_data, write_data);
    end
  endtask

  task automatic test_directed();
    logic [2:0] ops [4] = '{3'd0, 3'd1, 3'd5, 3'd6};
    logic [7:0] as  [4] = '{8'hF0, 8'h05, 8'h81, 8'h03};
    logic [7:0] bs  [4] = '{8'h20, 8'h07, 8'h01, 8'h01};
    logic [15:0] exp_v [4] = '{16'h0110, 16'h01FE, 16'h0102, 16'h8001};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      n_tests++;
      if ({done, write_enable, cout_write_enable, cout_data, write_data} !== {3'b111, exp_v[i]}) begin
        n_fail++;
        $display("FAIL directed_%0d: got done/we/cwe=%b cout=%h wd=%h expected 111 cout=%h wd=%h",
                 i, {done, write_enable, cout_write_enable}, cout_data, write_data,
                 exp_v[i][15:8], exp_v[i][7:0]);
      end
      a_i = ~a_i; b_i = ~b_i;
      tick();
      n_tests++;
      if ({done, write_enable, cout_data, write_data} !== {2'b00, exp_v[i]}) begin
        n_fail++;
        $display("FAIL hold_%0d: got done=%b we=%b cout=%h wd=%h expected 0 0 cout=%h wd=%h",
                 i, done, write_enable, cout_data, write_data, exp_v[i][15:8], exp_v[i][7:0]);
      end
    end
  endtask

  task automatic test_random_back_to_back();
    logic [2:0] o;
    logic [7:0] a, b;
    logic [15:0] e;
    for (int i = 0; i < 200; i++) begin
`ifdef EXEC_MUL_EN
      o = 3'($urandom_range(0, 6));
`else
      o = 3'($urandom_range(0, 7));
`endif
      a = 8'($urandom); b = 8'($urandom);
      e = model(o, a, b);
      start = 1'b1; op = o; a_i = a; b_i = b;
      tick();
      n_tests++;
      if ({done, cout_data, write_data} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL rand_op%0d a=%h b=%h: got done=%b cout=%h wd=%h expected 1 cout=%h wd=%h",
                 o, a, b, done, cout_data, write_data, e[15:8], e[7:0]);
      end
    end
    start = 1'b0;
    tick();
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul();
    logic [15:0] e;
    issue(3'd7, 8'hFF, 8'hFF);
    for (int k = 1; k <= 7; k++) begin
      if (k == 3) begin start = 1'b1; op = 3'd0; a_i = 8'h01; b_i = 8'h01; end
      tick();
      start = 1'b0;
      n_tests++;
      if ({busy, done} !== 2'b10) begin
        n_fail++;
        $display("FAIL mul_busy_c%0d: got busy/done=%b expected 10", k, {busy, done});
      end
    end
    tick();
    n_tests++;
    if ({busy, done, write_enable, cout_data, write_data} !== {3'b011, 16'hFE01}) begin
      n_fail++;
      $display("FAIL mul_done: got busy/done/we=%b cout=%h wd=%h expected 011 FE 01",
               {busy, done, write_enable}, cout_data, write_data);
    end
    // Back-to-back ADD issued during the done cycle.
    start = 1'b1; op = 3'd0; a_i = 8'hC3; b_i = 8'h5A;
    tick();
    start = 1'b0;
    e = model(3'd0, 8'hC3, 8'h5A);
    n_tests++;
    if ({done, busy, cout_data, write_data} !== {2'b10, e}) begin
      n_fail++;
      $display("FAIL b2b_add: got done/busy=%b cout=%h wd=%h expected 10 cout=%h wd=%h",
               {done, busy}, cout_data, write_data, e[15:8], e[7:0]);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_single_pulse: got done=%b expected 0", done);
    end
    for (int i = 0; i < 10; i++) begin
      int cyc;
      logic [7:0] a, b;
      a = 8'($urandom); b = 8'($urandom);
      e = model(3'd7, a, b);
      issue(3'd7, a, b);
      a_i = ~a; b_i = ~b;
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
        tick();
        cyc++;
      end
      n_tests++;
      if (cyc != 8 || {cout_data, write_data} !== e) begin
        n_fail++;
        $display("FAIL mul_rand a=%h b=%h: got latency=%0d product=%h expected 8 %h",
                 a, b, cyc, {cout_data, write_data}, e);
      end
      tick();
    end
  endtask

  task automatic test_mul_reset();
    int pulses;
    issue(3'd7, 8'h9A, 8'h77);
    for (int k = 1; k <= 4; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL mul_reset: got busy/done=%b expected 00", {busy, done});
    end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (write_enable !== 1'b0 || {cout_data, write_data} !== 16'h0000) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL mul_reset_quiet: got %0d bad cycles expected 0", pulses);
    end
  endtask
`else
  task automatic test_mov();
    issue(3'd7, 8'h12, 8'h34);
    n_tests++;
    if ({done, busy, cout_data, write_data} !== {2'b10, 16'h0034}) begin
      n_fail++;
      $display("FAIL mov: got done/busy=%b cout=%h wd=%h expected 10 00 34",
               {done, busy}, cout_data, write_data);
    end
    tick();
    n_tests++;
    if (busy_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_tied: got busy_seen=%b expected 0", busy_seen);
    end
  endtask
`endif

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_directed();
    test_random_back_to_back();
`ifdef EXEC_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mov();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
